cache_flush_sweep_generator: RTL

- Parametrised successor to the fixed-geometry system-cache flush sequence.
- Generates one backend line-read address per system-cache line (NUM_WAYS × NUM_SETS) so the downstream cache is fully evicted.
- Sits between the kernel control FSM and the backend AXI read-request arbiter.
- Adds a selectable sweep order, an outstanding-read credit limit, abort, and a completion count.

---
 rtl/cache_flush_sweep_generator_pkg.sv | 39 +++
 rtl/cache_flush_sweep_generator_credit.sv | 45 ++++
 rtl/cache_flush_sweep_generator.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cache_flush_sweep_generator_pkg.sv
// Shared types, mode encodings and address helper for the cache flush sweep generator.
package cache_flush_sweep_generator_pkg;

    typedef enum logic [4:0] {
        CFS_RESET = 5'b00001,
        CFS_IDLE  = 5'b00010,
        CFS_ISSUE = 5'b00100,
        CFS_DRAIN = 5'b01000,
        CFS_DONE  = 5'b10000
    } cache_flush_sweep_state;

    localparam logic CACHE_FLUSH_MODE_LINEAR = 1'b0;
    localparam logic CACHE_FLUSH_MODE_WAY    = 1'b1;

    // Widest address the helper supports; callers truncate to their own width.
    localparam int unsigned CFS_ADDR_MAX_W = 64;

    // Line address for sweep index c; geometry is passed as log2 shift amounts.
    function automatic logic [CFS_ADDR_MAX_W-1:0] cache_flush_sweep_addr(
        input logic [CFS_ADDR_MAX_W-1:0] base,
        input logic [31:0]               c,
        input logic                      mode,
        input int unsigned               line_sh,
        input int unsigned               way_bits,
        input int unsigned               way_sh
    );
        logic [CFS_ADDR_MAX_W-1:0] c_w;
        logic [CFS_ADDR_MAX_W-1:0] way;
        logic [CFS_ADDR_MAX_W-1:0] set;
        c_w = CFS_ADDR_MAX_W'(c);
        way = c_w & ((CFS_ADDR_MAX_W'(1) << way_bits) - CFS_ADDR_MAX_W'(1));
        set = c_w >> way_bits;
        if (mode == CACHE_FLUSH_MODE_WAY) begin
            return base + (way << way_sh) + (set << line_sh);
        end
        return base + (c_w << line_sh);
    endfunction

endpackage

// File: rtl/cache_flush_sweep_generator_credit.sv
// Saturating up/down counter of in-flight reads; flags reflect the value after this cycle.
module cache_flush_credit_counter #(
    parameter int unsigned MAX_COUNT = 16,
    localparam int unsigned CW = $clog2(MAX_COUNT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_nxt_c,
    output logic empty_nxt_c
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          dec_eff;

    // A completion with nothing outstanding is dropped rather than wrapping.
    always_comb begin
        dec_eff = dec_i && (count_q != '0);
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !dec_eff) begin
            if (count_q != CW'(MAX_COUNT)) begin
                count_d = count_q + CW'(1);
            end
        end else if (dec_eff && !inc_i) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign full_nxt_c  = (count_d == CW'(MAX_COUNT));
    assign empty_nxt_c = (count_d == '0);

endmodule

// File: rtl/cache_flush_sweep_generator.sv
// Issues one line-read per system-cache line to fully evict it, with credit limit and abort.
// Optional CACHE_FLUSH_SWEEP_PERF_EN adds busy-cycle and stall-cycle counters.
module cache_flush_sweep_generator
    import cache_flush_sweep_generator_pkg::*;
#(
    parameter int unsigned NUM_WAYS        = 4,
    parameter int unsigned LINE_BYTES      = 64,
    parameter int unsigned CACHE_SIZE_B    = 65536,
    parameter int unsigned ADDR_W          = 64,
    parameter int unsigned MAX_OUTSTANDING = 16,
    localparam int unsigned NUM_SETS  = CACHE_SIZE_B / (LINE_BYTES * NUM_WAYS),
    localparam int unsigned ITER      = NUM_WAYS * NUM_SETS,
    localparam int unsigned CNT_W     = $clog2(ITER) + 1,
    localparam int unsigned WAY_BYTES = CACHE_SIZE_B / NUM_WAYS
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              start_in,
    input  logic              abort_in,
    input  logic              mode_in,
    input  logic [ADDR_W-1:0] base_addr_in,
    output logic              req_valid_out,
    input  logic              req_ready_in,
    output logic [ADDR_W-1:0] req_addr_out,
    input  logic              resp_valid_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              aborted_out,
    output logic [CNT_W-1:0]  issued_count_out
`ifdef CACHE_FLUSH_SWEEP_PERF_EN
   ,output logic [31:0]       cycle_count_out,
    output logic [31:0]       stall_count_out
`endif
);

    localparam int unsigned LINE_SH  = $clog2(LINE_BYTES);
    localparam int unsigned WAY_BITS = $clog2(NUM_WAYS);
    localparam int unsigned WAY_SH   = $clog2(WAY_BYTES);

    cache_flush_sweep_state state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;

    logic start_acc;
    logic xfer;
    logic full_nxt;
    logic empty_nxt;

    assign start_acc = (state_q == CFS_IDLE) && start_in;
    // Abort retracts a pending request in the same cycle so it is never counted.
    assign req_valid_out = valid_q && !abort_in;
    assign xfer          = req_valid_out && req_ready_in;

    cache_flush_credit_counter #(
        .MAX_COUNT (MAX_OUTSTANDING)
    ) u_credit (
        .clk         (ap_clk),
        .rst_n       (ap_rst_n),
        .clr_i       (start_acc),
        .inc_i       (xfer),
        .dec_i       (resp_valid_in),
        .full_nxt_c  (full_nxt),
        .empty_nxt_c (empty_nxt)
    );

    // Next state plus next values of every registered output.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        mode_d    = mode_q;
        aborted_d = aborted_q;

        unique case (state_q)
            CFS_RESET: state_d = CFS_IDLE;
            CFS_IDLE: begin
                if (start_in) begin
                    state_d   = CFS_ISSUE;
                    base_d    = base_addr_in;
                    mode_d    = mode_in;
                    cnt_d     = '0;
                    aborted_d = 1'b0;
                end
            end
            CFS_ISSUE: begin
                if (abort_in) begin
                    state_d   = CFS_DRAIN;
                    aborted_d = 1'b1;
                end else if (xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(ITER)) begin
                        state_d = CFS_DRAIN;
                    end
                end
            end
            CFS_DRAIN: begin
                if (empty_nxt) begin
                    state_d = CFS_DONE;
                end
            end
            CFS_DONE: state_d = CFS_IDLE;
            default:  state_d = CFS_IDLE;
        endcase

        // Credit and count use next-cycle values so valid never overshoots the limit.
        valid_d = (state_d == CFS_ISSUE) && !full_nxt && (cnt_d < CNT_W'(ITER));
        addr_d  = '0;
        if (state_d == CFS_ISSUE) begin
            addr_d = ADDR_W'(cache_flush_sweep_addr(CFS_ADDR_MAX_W'(base_d), 32'(cnt_d),
                                                    mode_d, LINE_SH, WAY_BITS, WAY_SH));
        end
        busy_d = (state_d == CFS_ISSUE) || (state_d == CFS_DRAIN);
        done_d = (state_d == CFS_DONE);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q   <= CFS_RESET;
            cnt_q     <= '0;
            base_q    <= '0;
            mode_q    <= 1'b0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            base_q    <= base_d;
            mode_q    <= mode_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign req_addr_out     = addr_q;
    assign busy_out         = busy_q;
    assign done_out         = done_q;
    assign aborted_out      = aborted_q;
    assign issued_count_out = cnt_q;

`ifdef CACHE_FLUSH_SWEEP_PERF_EN
    logic [31:0] cycle_q;
    logic [31:0] stall_q;

    // Saturating busy-cycle and backpressure-cycle counters, cleared on start.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cycle_q <= '0;
            stall_q <= '0;
        end else if (start_acc) begin
            cycle_q <= '0;
            stall_q <= '0;
        end else begin
            if (busy_q && (cycle_q != '1)) begin
                cycle_q <= cycle_q + 32'd1;
            end
            if (req_valid_out && !req_ready_in && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign cycle_count_out = cycle_q;
    assign stall_count_out = stall_q;
`endif

endmodule
